// File: rtl/apb4_spi_arb.sv
// Shares one APB4 SPI master port between N_REQ requesters: round-robin with ownership lock, ACCESS timeout, irq steering.
// Latency: IDLE->SETUP->ACCESS, min 3 cycles per access; losers and locked-out requesters are held with pready low.
module apb4_spi_arb #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic [N_REQ-1:0]        s_psel,
  input  logic [N_REQ-1:0]        s_penable,
  input  logic [N_REQ-1:0]        s_pwrite,
  input  logic [N_REQ*ADDR_W-1:0] s_paddr,
  input  logic [N_REQ*32-1:0]     s_pwdata,
  input  logic [N_REQ-1:0]        s_lock,
  output logic [N_REQ*32-1:0]     s_prdata,
  output logic [N_REQ-1:0]        s_pready,
  output logic [N_REQ-1:0]        s_pslverr,
  output logic                    m_psel,
  output logic                    m_penable,
  output logic                    m_pwrite,
  output logic [ADDR_W-1:0]       m_paddr,
  output logic [31:0]             m_pwdata,
  input  logic [31:0]             m_prdata,
  input  logic                    m_pready,
  input  logic                    m_pslverr,
  input  logic                    spi_irq_i,
  output logic [N_REQ-1:0]        irq_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic          locked, locked_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;

  logic [N_REQ-1:0]   cand;
  logic [2*N_REQ-1:0] rot_dbl;
  logic [N_REQ-1:0]   rot;
  logic [IW-1:0]      off;
  logic [IW:0]        pick_sum;
  logic [IW:0]        inc_sum;
  logic [IW-1:0]      pick;
  logic               pick_vld;
  logic               tmo;
  logic               done;
  logic               active;

  logic [ADDR_W-1:0] paddr_a  [N_REQ];
  logic [31:0]       pwdata_a [N_REQ];

  // penable from requesters carries no information the arbiter needs
  logic unused_penable;
  assign unused_penable = ^s_penable;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      paddr_a[i]  = s_paddr[i*ADDR_W +: ADDR_W];
      pwdata_a[i] = s_pwdata[i*32 +: 32];
    end
  end

  // Rotate candidates so bit 0 is the round-robin pointer, then take the lowest set bit
  always_comb begin
    cand = s_psel;
    if (locked && s_lock[owner]) begin
      cand        = '0;
      cand[owner] = s_psel[owner];
    end
    rot_dbl  = {cand, cand} >> rr_ptr;
    rot      = rot_dbl[N_REQ-1:0];
    pick_vld = 1'b0;
    off      = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        pick_vld = 1'b1;
        off      = IW'(j);
      end
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, off};
    if (pick_sum >= (IW+1)'(N_REQ)) pick_sum = pick_sum - (IW+1)'(N_REQ);
    pick = pick_sum[IW-1:0];
    inc_sum = {1'b0, owner} + (IW+1)'(1);
    if (inc_sum >= (IW+1)'(N_REQ)) inc_sum = '0;
  end

  assign active = (state != IDLE);
  assign tmo    = (TIMEOUT > 0) && (state == ACCESS) && !m_pready && (tcnt == T_LAST);
  assign done   = (state == ACCESS) && (m_pready || tmo);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      locked <= 1'b0;
      tcnt   <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      locked <= locked_nxt;
      tcnt   <= tcnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    locked_nxt = locked;
    tcnt_nxt   = tcnt;
    case (state)
      IDLE: begin
        if (locked && !s_lock[owner]) locked_nxt = 1'b0;
        if (pick_vld) begin
          owner_nxt = pick;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        tcnt_nxt  = '0;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        tcnt_nxt = tcnt + TW'(1);
        if (done) begin
          state_nxt  = IDLE;
          tcnt_nxt   = '0;
          locked_nxt = s_lock[owner];
          if (!locked) rr_ptr_nxt = inc_sum[IW-1:0];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_psel    = active;
    m_penable = (state == ACCESS);
    m_pwrite  = active && s_pwrite[owner];
    m_paddr   = active ? paddr_a[owner]  : '0;
    m_pwdata  = active ? pwdata_a[owner] : '0;
    s_prdata  = '0;
    s_pready  = '0;
    s_pslverr = '0;
    irq_o     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if ((state == ACCESS) && (owner == IW'(i))) begin
        s_pready[i]        = m_pready || tmo;
        s_pslverr[i]       = m_pslverr || tmo;
        s_prdata[i*32 +: 32] = tmo ? 32'h0 : m_prdata;
      end
      irq_o[i] = spi_irq_i && (owner == IW'(i));
    end
  end

endmodule

// File: tb/tb_apb4_spi_arb.sv
// Scoreboard bench for apb4_spi_arb: stimulus pushes expected completions, a monitor pops them on s_pready.
module tb_apb4_spi_arb;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [1:0]  s_psel, s_penable, s_pwrite, s_lock;
  logic [23:0] s_paddr;
  logic [63:0] s_pwdata;
  logic [63:0] s_prdata;
  logic [1:0]  s_pready, s_pslverr;
  logic        m_psel, m_penable, m_pwrite;
  logic [11:0] m_paddr;
  logic [31:0] m_pwdata, m_prdata;
  logic        m_pready, m_pslverr;
  logic        spi_irq_i;
  logic [1:0]  irq_o;
  logic        slv_rdy;

  logic [11:0] paddr_a  [2];
  logic [31:0] pwdata_a [2];
  assign s_paddr  = {paddr_a[1], paddr_a[0]};
  assign s_pwdata = {pwdata_a[1], pwdata_a[0]};

  // SPI master stand-in: read data encodes the address, 0xFFC answers with an error
  assign m_pready  = slv_rdy;
  assign m_prdata  = m_psel ? {20'hC0DE0, m_paddr} : 32'h0;
  assign m_pslverr = m_psel && (m_paddr == 12'hFFC);

  apb4_spi_arb #(.N_REQ(2), .ADDR_W(12), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_lock(s_lock),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr),
    .spi_irq_i(spi_irq_i), .irq_o(irq_o)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          req;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   setup_c  = 0;
  int   acc_c    = 0;
  logic [1:0]  one_hot;
  logic [63:0] exp_rd;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic push(input int req, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input logic err, input int acc);
    exp_t x;
    x.req = req; x.wr = wr; x.addr = a; x.wdata = wd; x.rdata = rd; x.err = err; x.acc = acc;
    sbq.push_back(x);
  endtask

  task automatic apb_xfer(input int i, input logic wr, input logic [11:0] a, input logic [31:0] d,
                          input logic lk);
    int n;
    s_psel[i]    = 1'b1;
    s_penable[i] = 1'b0;
    s_pwrite[i]  = wr;
    paddr_a[i]   = a;
    pwdata_a[i]  = d;
    s_lock[i]    = lk;
    @(posedge pclk); #1;
    s_penable[i] = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge pclk);
      if (s_pready[i]) break;
      n++;
    end
    check($sformatf("xfer_done_req%0d", i), 64'(n < 100), 64'd1);
    @(posedge pclk); #1;
    s_psel[i]    = 1'b0;
    s_penable[i] = 1'b0;
  endtask

  initial begin
    presetn = 1'b0;
    s_psel = '0; s_penable = '0; s_pwrite = '0; s_lock = '0;
    paddr_a[0] = '0; paddr_a[1] = '0; pwdata_a[0] = '0; pwdata_a[1] = '0;
    spi_irq_i = 1'b0;
    slv_rdy   = 1'b1;
    fork
      forever begin
        @(negedge pclk);
        if (!presetn) begin
          setup_c = 0;
          acc_c   = 0;
        end else begin
          if (m_psel && !m_penable) setup_c++;
          if (m_psel && m_penable) acc_c++;
          if (s_pready != 2'b00) begin
            if (sbq.size() == 0) begin
              check("unexpected_pready", 64'(s_pready), 64'd0);
            end else begin
              e       = sbq.pop_front();
              one_hot = 2'b01 << e.req;
              exp_rd  = 64'(e.rdata) << (32 * e.req);
              check($sformatf("pready_req%0d", e.req), 64'(s_pready), 64'(one_hot));
              check($sformatf("pslverr_req%0d", e.req), 64'(s_pslverr), e.err ? 64'(one_hot) : 64'd0);
              check($sformatf("prdata_req%0d", e.req), s_prdata, exp_rd);
              check("m_paddr", 64'(m_paddr), 64'(e.addr));
              check("m_pwrite", 64'(m_pwrite), 64'(e.wr));
              if (e.wr) check("m_pwdata", 64'(m_pwdata), 64'(e.wdata));
              check("setup_cycles", 64'(setup_c), 64'd1);
              check("access_cycles", 64'(acc_c), 64'(e.acc));
            end
            setup_c = 0;
            acc_c   = 0;
          end
          if (!m_psel) begin
            setup_c = 0;
            acc_c   = 0;
          end
        end
      end
      begin
        // reset state
        #12;
        check("rst_m_psel", 64'(m_psel), 64'd0);
        check("rst_m_penable", 64'(m_penable), 64'd0);
        check("rst_m_pwrite", 64'(m_pwrite), 64'd0);
        check("rst_m_paddr", 64'(m_paddr), 64'd0);
        check("rst_m_pwdata", 64'(m_pwdata), 64'd0);
        check("rst_s_pready", 64'(s_pready), 64'd0);
        check("rst_s_pslverr", 64'(s_pslverr), 64'd0);
        check("rst_s_prdata", s_prdata, 64'd0);
        check("rst_irq_low", 64'(irq_o), 64'd0);
        spi_irq_i = 1'b1; #1;
        check("rst_irq_owner0", 64'(irq_o), 64'b01);
        spi_irq_i = 1'b0;
        @(posedge pclk); #1 presetn = 1'b1;

        // single write, then a read from the other requester
        push(0, 1'b1, 12'h008, 32'h0000_00A5, 32'hC0DE_0008, 1'b0, 1);
        apb_xfer(0, 1'b1, 12'h008, 32'h0000_00A5, 1'b0);
        push(1, 1'b0, 12'h010, 32'h0, 32'hC0DE_0010, 1'b0, 1);
        apb_xfer(1, 1'b0, 12'h010, 32'h0, 1'b0);

        // two simultaneous pairs; pointer returns to 0 after Req1 each time
        push(0, 1'b1, 12'h020, 32'h1111_1111, 32'hC0DE_0020, 1'b0, 1);
        push(1, 1'b0, 12'h024, 32'h0, 32'hC0DE_0024, 1'b0, 1);
        fork
          apb_xfer(0, 1'b1, 12'h020, 32'h1111_1111, 1'b0);
          apb_xfer(1, 1'b0, 12'h024, 32'h0, 1'b0);
        join
        push(0, 1'b1, 12'h028, 32'h2222_2222, 32'hC0DE_0028, 1'b0, 1);
        push(1, 1'b0, 12'hFFC, 32'h0, 32'hC0DE_0FFC, 1'b1, 1);
        fork
          apb_xfer(0, 1'b1, 12'h028, 32'h2222_2222, 1'b0);
          apb_xfer(1, 1'b0, 12'hFFC, 32'h0, 1'b0);
        join

        // Req1 locks over three accesses, Req0 waits until the lock drops
        push(1, 1'b0, 12'h030, 32'h0, 32'hC0DE_0030, 1'b0, 1);
        push(1, 1'b0, 12'h034, 32'h0, 32'hC0DE_0034, 1'b0, 1);
        push(1, 1'b0, 12'h038, 32'h0, 32'hC0DE_0038, 1'b0, 1);
        push(0, 1'b1, 12'h03C, 32'h3333_3333, 32'hC0DE_003C, 1'b0, 1);
        fork
          begin
            apb_xfer(1, 1'b0, 12'h030, 32'h0, 1'b1);
            apb_xfer(1, 1'b0, 12'h034, 32'h0, 1'b1);
            apb_xfer(1, 1'b0, 12'h038, 32'h0, 1'b1);
            s_lock[1] = 1'b0;
          end
          begin
            @(posedge pclk); #1;
            apb_xfer(0, 1'b1, 12'h03C, 32'h3333_3333, 1'b0);
          end
        join

        // stuck slave: abort in the 16th ACCESS cycle with error and zero data
        slv_rdy = 1'b0;
        push(0, 1'b0, 12'h040, 32'h0, 32'h0, 1'b1, 16);
        apb_xfer(0, 1'b0, 12'h040, 32'h0, 1'b0);
        @(negedge pclk);
        check("idle_after_timeout", 64'(m_psel), 64'd0);

        // reset during ACCESS
        s_psel[0] = 1'b1; s_pwrite[0] = 1'b0; paddr_a[0] = 12'h044;
        @(posedge pclk); #1 s_penable[0] = 1'b1;
        @(posedge pclk); #1;
        check("in_access_before_reset", 64'(m_penable), 64'd1);
        presetn = 1'b0; #1;
        check("mid_rst_m_psel", 64'(m_psel), 64'd0);
        check("mid_rst_m_penable", 64'(m_penable), 64'd0);
        check("mid_rst_m_paddr", 64'(m_paddr), 64'd0);
        check("mid_rst_s_pready", 64'(s_pready), 64'd0);
        check("mid_rst_s_pslverr", 64'(s_pslverr), 64'd0);
        check("mid_rst_s_prdata", s_prdata, 64'd0);
        s_psel[0] = 1'b0; s_penable[0] = 1'b0;
        slv_rdy = 1'b1;
        @(posedge pclk); #1 presetn = 1'b1;
        push(0, 1'b1, 12'h008, 32'h0000_00A5, 32'hC0DE_0008, 1'b0, 1);
        apb_xfer(0, 1'b1, 12'h008, 32'h0000_00A5, 1'b0);

        // interrupt follows the owner
        push(1, 1'b0, 12'h050, 32'h0, 32'hC0DE_0050, 1'b0, 1);
        apb_xfer(1, 1'b0, 12'h050, 32'h0, 1'b0);
        spi_irq_i = 1'b1; #1;
        check("irq_owner1", 64'(irq_o), 64'b10);
        spi_irq_i = 1'b0; #1;
        check("irq_off", 64'(irq_o), 64'b00);
        push(0, 1'b1, 12'h054, 32'h0000_0055, 32'hC0DE_0054, 1'b0, 1);
        apb_xfer(0, 1'b1, 12'h054, 32'h0000_0055, 1'b0);
        spi_irq_i = 1'b1; #1;
        check("irq_owner0", 64'(irq_o), 64'b01);
        spi_irq_i = 1'b0;

        repeat (3) @(posedge pclk);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
      end
      begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL global_watchdog: simulation time limit reached");
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
